// File: rtl/sim_dac_pkg.sv
// Shared types and helpers for the simulator DAC path: controller states,
// output full-scale code and the saturating counter increment.
package sim_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_SETTLE = 2'd3
    } ctrl_state_e;

    localparam int unsigned DAC_BITS = 12;
    localparam logic [DAC_BITS-1:0] FULL_SCALE = 12'hFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/clip_offset_ctrl_sat_counter16.sv
// 16-bit saturating event counter with synchronous clear (clear wins).
// Only built when CLIP_OFFSET_STATS_EN is defined.
`ifdef CLIP_OFFSET_STATS_EN
module sat_counter16
    import sim_dac_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: clear, saturating increment or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 16'h0000;
        end else if (inc_i) begin
            cnt_d = sat_inc16(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/clip_offset_ctrl.sv
// Closed-loop pedestal controller for the clip stage offset, with optional
// saturating clip statistics (enabled by CLIP_OFFSET_STATS_EN).
module clip_offset_ctrl
    import sim_dac_pkg::*;
#(
    parameter int BITS_IN    = 34,
    parameter int BITS_OUT   = 12,
    parameter int WIN_LOG    = 10,
    parameter int SETTLE_CYC = 8,
    parameter int DEADBAND   = 2,
    parameter int LOCK_WINS  = 4,
    parameter int OFFSET_LIM = 2047
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       auto_en_i,
    input  logic signed [BITS_IN-1:0]  manual_offset_i,
    input  logic        [BITS_OUT-1:0] target_i,
    input  logic                       sample_valid_i,
    input  logic        [BITS_OUT-1:0] sample_i,
    input  logic                       stats_clr_i,
    output logic signed [BITS_IN-1:0]  offset_o,
    output logic                       locked_o,
    output logic                       busy_o,
    output logic        [15:0]         clip_lo_cnt_o,
    output logic        [15:0]         clip_hi_cnt_o
);

    localparam int ACC_W = BITS_OUT + WIN_LOG;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int IB_W  = $clog2(LOCK_WINS + 1);

    localparam logic signed [BITS_IN:0]  LIM_P  = (BITS_IN+1)'(OFFSET_LIM);
    localparam logic signed [BITS_IN:0]  ONE_P  = (BITS_IN+1)'(1);
    localparam logic        [BITS_OUT:0] DB_P   = (BITS_OUT+1)'(DEADBAND);
    localparam logic        [IB_W-1:0]   LOCK_P = IB_W'(LOCK_WINS);
    localparam logic        [SET_W-1:0]  SET_P  = SET_W'(SETTLE_CYC - 1);

    ctrl_state_e                state_q, state_d;
    logic        [ACC_W-1:0]    acc_q, acc_d;
    logic        [WIN_LOG-1:0]  cnt_q, cnt_d;
    logic        [SET_W-1:0]    set_q, set_d;
    logic        [IB_W-1:0]     inband_q, inband_d;
    logic signed [BITS_IN-1:0]  offset_q, offset_d;
    logic                       locked_q, busy_q;

    logic        [BITS_OUT-1:0] mean_s;
    logic signed [BITS_OUT:0]   err_s, err_neg_s;
    logic        [BITS_OUT:0]   err_mag_s;
    logic                       in_band_s;
    logic signed [BITS_IN:0]    off_ext_s, cand_s, clamp_s;

    // Truncating window mean and signed error against the target.
    assign mean_s    = acc_q[ACC_W-1 -: BITS_OUT];
    assign err_s     = $signed({1'b0, target_i}) - $signed({1'b0, mean_s});
    assign err_neg_s = -err_s;
    assign err_mag_s = err_s[BITS_OUT] ? err_neg_s : err_s;
    assign in_band_s = (err_mag_s <= DB_P);

    // One-LSB step toward the target, clamped; one extra bit avoids wrap.
    always_comb begin
        off_ext_s = {offset_q[BITS_IN-1], offset_q};
        if (err_s[BITS_OUT]) begin
            cand_s = off_ext_s - ONE_P;
        end else begin
            cand_s = off_ext_s + ONE_P;
        end
        if (cand_s > LIM_P) begin
            clamp_s = LIM_P;
        end else if (cand_s < -LIM_P) begin
            clamp_s = -LIM_P;
        end else begin
            clamp_s = cand_s;
        end
    end

    // Control FSM next state; dropping auto_en aborts from any state.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        set_d    = set_q;
        inband_d = inband_q;
        offset_d = offset_q;
        if (!auto_en_i) begin
            state_d  = ST_IDLE;
            acc_d    = '0;
            cnt_d    = '0;
            set_d    = '0;
            inband_d = '0;
            offset_d = manual_offset_i;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
                ST_ACCUM: begin
                    if (sample_valid_i) begin
                        acc_d = acc_q + ACC_W'(sample_i);
                        cnt_d = cnt_q + WIN_LOG'(1);
                        if (cnt_q == {WIN_LOG{1'b1}}) begin
                            state_d = ST_UPDATE;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_UPDATE: begin
                    state_d = ST_SETTLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    set_d   = '0;
                    if (in_band_s) begin
                        if (inband_q != LOCK_P) begin
                            inband_d = inband_q + IB_W'(1);
                        end else begin
                            inband_d = inband_q;
                        end
                    end else begin
                        inband_d = '0;
                        offset_d = clamp_s[BITS_IN-1:0];
                    end
                end
                ST_SETTLE: begin
                    if (set_q == SET_P) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        set_d = set_q + SET_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Loop state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            set_q    <= '0;
            inband_q <= '0;
            offset_q <= '0;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            set_q    <= set_d;
            inband_q <= inband_d;
            offset_q <= offset_d;
            locked_q <= (inband_d == LOCK_P);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign offset_o = offset_q;
    assign locked_o = locked_q;
    assign busy_o   = busy_q;

`ifdef CLIP_OFFSET_STATS_EN
    logic lo_hit_s, hi_hit_s;

    assign lo_hit_s = sample_valid_i && (sample_i == {BITS_OUT{1'b0}});
    assign hi_hit_s = sample_valid_i && (sample_i == FULL_SCALE);

    sat_counter16 u_clip_lo (
        .clk   (clk),
        .rst   (rst),
        .clr_i (stats_clr_i),
        .inc_i (lo_hit_s),
        .cnt_o (clip_lo_cnt_o)
    );

    sat_counter16 u_clip_hi (
        .clk   (clk),
        .rst   (rst),
        .clr_i (stats_clr_i),
        .inc_i (hi_hit_s),
        .cnt_o (clip_hi_cnt_o)
    );
`else
    logic stats_clr_unused_s;

    assign stats_clr_unused_s = stats_clr_i;
    assign clip_lo_cnt_o      = 16'h0000;
    assign clip_hi_cnt_o      = 16'h0000;
`endif

endmodule

// File: doc/clip_offset_ctrl.md
# clip_offset_ctrl

Closed-loop pedestal controller for the 12-bit clip/shaper output stage of the simulator DAC path. It observes the shaped, clipped output samples and drives the signed `offset` input of the clip stage. In auto mode it steers the window mean of the output toward an HPS-programmed target. It also keeps saturating under/over-range statistics for the HPS. It sits between the HPS configuration registers and the clip stage, one instance per DAC channel.

## Interface
- `BITS_IN`, 34: width of the signed offset driven to the clip stage.
- `BITS_OUT`, 12: width of the observed unsigned output sample; full scale is 2^BITS_OUT-1.
- `WIN_LOG`, 10: averaging window of 2^WIN_LOG valid samples.
- `SETTLE_CYC`, 8: cycles to ignore samples after an offset change.
- `DEADBAND`, 2: allowed |target − mean| for a window to count as in-band.
- `LOCK_WINS`, 4: consecutive in-band windows required to assert `locked`.
- `OFFSET_LIM`, 2047: offset clamp magnitude; offset stays in [−OFFSET_LIM, +OFFSET_LIM].

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `auto_en`  in  1  1 = closed loop, 0 = manual.
- `manual_offset`  in  BITS_IN signed  offset applied in manual mode.
- `target`  in  BITS_OUT  desired window mean in auto mode.
- `sample_valid`  in  1  qualifies `sample`.
- `sample`  in  BITS_OUT  clip-stage output.
- `stats_clr`  in  1  single-cycle clear of the clip counters.
- `offset`  out  BITS_IN signed  registered offset to the clip stage.
- `locked`  out  1  loop converged.
- `busy`  out  1  high in ACCUM, UPDATE and SETTLE.
- `clip_lo_cnt`  out  16  count of samples equal to 0.
- `clip_hi_cnt`  out  16  count of samples equal to full scale.

## Operation
- States:
  - IDLE: manual mode. `offset` tracks `manual_offset`, registered with 1-cycle delay. `locked` is 0.
  - ACCUM: each valid sample is added to an accumulator (BITS_OUT+WIN_LOG bits) and a sample counter is incremented.
  - UPDATE: one cycle.
  - SETTLE: lasts SETTLE_CYC cycles; samples are ignored. Then return to ACCUM with the accumulator and sample counter cleared.
- Transitions:
  - IDLE → ACCUM when `auto_en` = 1. The loop starts from the current `offset` value.
  - ACCUM → UPDATE on the cycle after the 2^WIN_LOG-th valid sample is accepted.
  - Any state → IDLE when `auto_en` = 0. Takes effect the next cycle. The current window is discarded, `locked` is cleared, and `offset` loads `manual_offset`.
- UPDATE arithmetic:
  - mean = acc >> WIN_LOG (truncating).
  - err = target − mean, signed, width BITS_OUT+1.
  - If |err| ≤ DEADBAND: increment the in-band counter, which saturates at LOCK_WINS. `offset` is unchanged.
  - Otherwise: `offset` ± 1 in the direction of sign(err), clamped to ±OFFSET_LIM. The in-band counter is cleared.
- Offset scaling: one offset LSB moves the shaped output by one code.
- `locked` = (in-band counter == LOCK_WINS). It deasserts on the first out-of-band window.
- Clip statistics:
  - Counted on every valid sample in every state.
  - Saturate at 16'hFFFF, with no wrap.
  - `stats_clr` has priority over an increment in the same cycle.

## Timing
- Reset values:
  - state = IDLE
  - `offset` = 0
  - `locked` = 0
  - `busy` = 0
  - both counters = 0
  - accumulator = 0
  - in-band counter = 0
- Offset update is visible on `offset` the cycle after UPDATE, i.e. 2 cycles after the final window sample is accepted.
- Window cycle: minimum 2^WIN_LOG + 1 + SETTLE_CYC cycles with continuous `sample_valid`. Gaps in `sample_valid` stretch ACCUM only.
- A sample arriving in the UPDATE cycle is ignored for averaging but still counted in the clip statistics.
- A `manual_offset` change while in IDLE appears on `offset` 1 cycle later.
- Reset asserted mid-window forces all reset values immediately; no state persists.

## Configuration
- `CLIP_OFFSET_STATS_EN`:
  - Defined: the clip counters and `stats_clr` are implemented as above.
  - Undefined: the counters are not synthesised, `clip_lo_cnt` and `clip_hi_cnt` are tied to 0, and `stats_clr` is ignored.
- Loop behaviour is identical in both cases.

## Structure
- Shared package `sim_dac_pkg` holds:
  - the state enum (IDLE, ACCUM, UPDATE, SETTLE);
  - the full-scale constant 2^BITS_OUT−1;
  - the saturating-increment function used by the clip counters.
- One sub-module, `sat_counter16`, instantiated twice for the clip counters, under the macro only.

## Test plan
Bench settings: WIN_LOG = 4, SETTLE_CYC = 2, DEADBAND = 2, LOCK_WINS = 4.
- Reset, then `auto_en` = 0, `manual_offset` = −37 → `offset` = −37 one cycle later; `busy` = 0; `locked` = 0.
- Auto mode, target = 2048, constant sample 2040, continuous valid → `offset` increments by exactly +1 every 19 cycles. First change appears 2 cycles after the 16th sample.
- Auto mode, samples equal to target ±1 for 4 windows → `offset` unchanged; `locked` rises after the 4th UPDATE. A following window with mean = target+5 → `locked` falls and `offset` decrements by 1.
- Offset at +OFFSET_LIM, mean persistently below target → `offset` holds at 2047 and never exceeds it.
- Samples of 0 and 4095 with `stats_clr` pulsed in the same cycle as a 4095 sample → `clip_hi_cnt` reads 0 the next cycle. Preloading `clip_lo_cnt` to 65535 → it stays at 65535. With the macro undefined, both counters read 0.
- `auto_en` dropped after 7 samples of a window, then raised again → `locked` = 0 and `offset` = `manual_offset`. The next window needs a full 16 new samples before UPDATE.
